// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: shares one SPI byte engine between two requesters
// (0 = CPU I/O port, 1 = boot/flash fetcher). Grants one requester at a time,
// drives its active-low chip select and sequences a len+1 byte transaction.
// Optional feature macro: SPI_ARB_TIMEOUT_EN (per-byte watchdog, sticky err).
module spi_txn_arbiter #(
  parameter int LEN_W          = 8,
  parameter int CS_SETUP       = 2,
  parameter int CS_HOLD        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [2*LEN_W-1:0] len,
  input  logic [15:0]        tx_data,
  output logic [1:0]         tx_ack,
  output logic [7:0]         rx_data,
  output logic [1:0]         rx_valid,
  output logic [1:0]         grant,
  output logic [1:0]         done,
  output logic               err,
  output logic [1:0]         cs_n,
  output logic [7:0]         core_data_tx,
  output logic               core_have_data,
  input  logic [7:0]         core_data_rx,
  input  logic               core_done
);

  localparam int MAX_SH  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_MAX = (TIMEOUT_CYCLES > MAX_SH) ? TIMEOUT_CYCLES : MAX_SH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

`ifdef SPI_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, SETUP, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD, GAP
  } state_t;

  state_t           state, state_nxt;
  logic             owner;       // requester holding the current grant
  logic             last_grant;  // round-robin history
  logic             win;         // arbitration winner while in IDLE
  logic [LEN_W-1:0] bcnt;        // bytes remaining after the current one
  logic [CNT_W-1:0] cnt;         // setup/hold/watchdog cycle counter
  logic             cnt_run;
  logic             to_hit;
  logic             issue;
  logic             err_q;

  // Both requesting: whoever did not go last wins; otherwise the lone requester.
  assign win = (req == 2'b11) ? ~last_grant : req[1];

  // Counter runs only in timed states; WAIT states only when the watchdog exists.
  assign cnt_run = (state == SETUP) || (state == HOLD) ||
                   (TO_EN && ((state == WAIT_BUSY) || (state == WAIT_DONE)));
  assign to_hit  = TO_EN && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (|req) state_nxt = SETUP;
      SETUP:     if (cnt == CNT_W'(CS_SETUP - 1)) state_nxt = ISSUE;
      ISSUE:     if (core_done) state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!core_done)  state_nxt = WAIT_DONE;
        else if (to_hit) state_nxt = HOLD;
      end
      WAIT_DONE: begin
        if (core_done)   state_nxt = (bcnt == '0) ? HOLD : ISSUE;
        else if (to_hit) state_nxt = HOLD;
      end
      HOLD:      if (cnt == CNT_W'(CS_HOLD - 1)) state_nxt = GAP;
      GAP:       state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Issue strobe, tx ack and outgoing byte are all qualified by the same cycle.
  always_comb begin
    issue          = (state == ISSUE) && core_done;
    core_have_data = issue;
    tx_ack         = 2'b00;
    core_data_tx   = 8'h00;
    if (issue) begin
      tx_ack       = owner ? 2'b10 : 2'b01;
      core_data_tx = owner ? tx_data[15:8] : tx_data[7:0];
    end
  end

  // Datapath: grant, byte counter, rx capture, pulses, watchdog flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      bcnt       <= '0;
      grant      <= 2'b00;
      rx_data    <= 8'h00;
      rx_valid   <= 2'b00;
      done       <= 2'b00;
      err_q      <= 1'b0;
    end else begin
      rx_valid <= 2'b00;
      done     <= 2'b00;
      if (state_nxt != state) cnt <= '0;
      else if (cnt_run)       cnt <= cnt + CNT_W'(1);
      case (state)
        IDLE: if (|req) begin
          owner <= win;
          grant <= win ? 2'b10 : 2'b01;
          bcnt  <= win ? len[2*LEN_W-1:LEN_W] : len[LEN_W-1:0];
        end
        WAIT_BUSY: if (core_done && to_hit) err_q <= 1'b1;
        WAIT_DONE: begin
          if (core_done) begin
            rx_data         <= core_data_rx;
            rx_valid[owner] <= 1'b1;
            if (bcnt != '0) bcnt <= bcnt - LEN_W'(1);
          end else if (to_hit) begin
            err_q <= 1'b1;
          end
        end
        HOLD: if (cnt == CNT_W'(CS_HOLD - 1)) begin
          grant       <= 2'b00;
          done[owner] <= 1'b1;
          last_grant  <= owner;
        end
        default: ;
      endcase
    end
  end

  assign err  = err_q;
  // Chip selects follow grant; gated with rst so they release the same instant.
  assign cs_n = rst ? 2'b11 : ~grant;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter: random and directed transactions
// against a transaction-level reference model plus a behavioural byte engine.
module tb_spi_txn_arbiter;
  localparam int LEN_W = 8, CS_SETUP = 2, CS_HOLD = 2, TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] len;
  logic [7:0]  txb [2];
  logic [15:0] tx_data;
  logic [1:0]  tx_ack, rx_valid, grant, done, cs_n;
  logic [7:0]  rx_data, core_data_tx, core_data_rx;
  logic        err, core_have_data, core_done;

  assign tx_data = {txb[1], txb[0]};
  always #5 clk = ~clk;

  spi_txn_arbiter #(.LEN_W(LEN_W), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD),
                    .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .len(len), .tx_data(tx_data),
    .tx_ack(tx_ack), .rx_data(rx_data), .rx_valid(rx_valid), .grant(grant),
    .done(done), .err(err), .cs_n(cs_n), .core_data_tx(core_data_tx),
    .core_have_data(core_have_data), .core_data_rx(core_data_rx),
    .core_done(core_done));

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int w);
    return (w != 0) ? 2'b10 : 2'b01;
  endfunction

  // ---------------- reference model state ----------------
  bit         active, hang, seq_mode, pend;
  int         mw, wsel, exp_bytes, issued, rxcnt, cyc, gcyc, last_rx_cyc;
  int         done_cnt, last_w, busy;
  logic [1:0] prev_grant, prev_req, prev_done, gn;
  logic [15:0] prev_len;
  logic [7:0] resp;
  logic [7:0] exp_rx [$];
  int         win_q [$];
  logic [7:0] last_rx [2];
  logic [7:0] last_tx [2];

  // Monitor + model + engine + requester data, all at the falling edge.
  initial begin
    core_done = 1'b1; core_data_rx = 8'h00; txb[0] = 8'h00; txb[1] = 8'h00;
    active = 0; pend = 0; busy = 0; done_cnt = 0; last_w = 1; cyc = 0;
    hang = 0; seq_mode = 0; prev_grant = 0; prev_req = 0; prev_done = 0; prev_len = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        active = 0; last_w = 1; prev_grant = 0; prev_done = 0; prev_req = 0;
        core_done = 1'b1; pend = 0; busy = 0; exp_rx.delete();
        continue;
      end
      gn = ~grant;
      check("cs_tracks_grant", cs_n, gn);
      check("grant_onehot", $countones(grant) <= 1, 1);
      if (prev_done != 0) check("gap_no_grant", grant, 0);
      // transaction start: winner predicted from the request seen in IDLE
      if (grant != 0 && prev_grant == 0) begin
        if (prev_req == 2'b01)      wsel = 0;
        else if (prev_req == 2'b10) wsel = 1;
        else                        wsel = 1 - last_w;
        check("arb_winner", grant, oh(wsel));
        check("req_seen", prev_req != 0, 1);
        mw = wsel; active = 1; issued = 0; rxcnt = 0; gcyc = cyc;
        exp_bytes = int'(wsel != 0 ? prev_len[15:8] : prev_len[7:0]) + 1;
        win_q.push_back(wsel);
      end
      if (rx_valid != 0) begin
        check("rx_owner", rx_valid, active ? oh(mw) : 2'b00);
        rxcnt++;
        check("rx_le_issued", rxcnt <= issued, 1);
        if (exp_rx.size() > 0) check("rx_data", rx_data, exp_rx.pop_front());
        last_rx[mw] = rx_data; last_rx_cyc = cyc;
      end
      if (active) check("tx_ack", tx_ack, core_have_data ? oh(mw) : 2'b00);
      else        check("idle_quiet", {tx_ack, core_have_data}, 0);
      if (core_have_data && active) begin
        if (issued == 0) check("first_issue_latency", cyc - gcyc, CS_SETUP);
        check("tx_byte", core_data_tx, txb[mw]);
        issued++;
        check("issue_le_len", issued <= exp_bytes, 1);
        exp_rx.push_back(txb[mw] ^ 8'h99);
        last_tx[mw] = core_data_tx;
      end
      if (active && done == 0) check("grant_held", grant, oh(mw));
      if (done != 0) begin
        check("done_owner", done, active ? oh(mw) : 2'b00);
        check("done_grant_low", grant, 0);
        if (active) begin
          if (hang) begin
            check("timeout_rx", rxcnt, issued - 1);
            check("timeout_err", err, 1);
          end else begin
            check("bytes_issued", issued, exp_bytes);
            check("bytes_rx", rxcnt, exp_bytes);
            check("cs_hold_len", cyc - last_rx_cyc, CS_HOLD);
            check("err_clear", err, 0);
          end
          last_w = mw;
        end
        active = 0; exp_rx.delete(); done_cnt++;
      end
      if (!hang) check("err_low", err, 0);
      prev_grant = grant; prev_req = req; prev_len = len; prev_done = done;
      // byte engine: accept one cycle after the strobe, finish 1..4 cycles later
      if (pend) begin
        core_done = 1'b0; busy = $urandom_range(1, 4);
      end else if (busy > 0 && !hang) begin
        busy--;
        if (busy == 0) begin core_done = 1'b1; core_data_rx = resp; end
      end
      pend = core_have_data;
      if (core_have_data) resp = core_data_tx ^ 8'h99;
      // requesters present their next byte once the current one is acked
      for (int w = 0; w < 2; w++)
        if (tx_ack[w]) txb[w] = seq_mode ? txb[w] + 8'd1 : 8'($urandom);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset;
    rst = 1'b1; req = 2'b00; hang = 0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic run_txn(input logic [1:0] r, input logic [7:0] l0, input logic [7:0] l1,
                         input int n);
    int start, b;
    start = done_cnt; len = {l1, l0}; req = r; b = 0;
    while (done_cnt < start + n && b < 20000) begin tick(1); b++; end
    req = 2'b00;
    check("txn_done_count", done_cnt - start, n);
  endtask

  int d0, b;

  initial begin
    rst = 1'b1; req = 2'b00; len = 16'h0;
    #1;
    check("reset_outputs",
          {grant, cs_n, tx_ack, rx_valid, done, err, core_have_data, core_data_tx, rx_data},
          {2'b00, 2'b11, 24'h0});
    do_reset;

    // single byte
    txb[0] = 8'hA5;
    run_txn(2'b01, 8'd0, 8'd0, 1);
    check("s1_tx", last_tx[0], 8'hA5);
    check("s1_rx", last_rx[0], 8'h3C);
    check("s1_cs_after", cs_n, 2'b11);

    // four sequential bytes
    seq_mode = 1; txb[0] = 8'h01;
    run_txn(2'b01, 8'd3, 8'd0, 1);
    seq_mode = 0;
    check("s2_last_tx", last_tx[0], 8'h04);

    // both requesting from reset: strict alternation starting with 0
    do_reset;
    win_q.delete();
    run_txn(2'b11, 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 4);
    check("s3_count", win_q.size(), 4);
    for (int i = 0; i < win_q.size(); i++) check("s3_order", win_q[i], i % 2);

    // request dropped right after grant still completes
    d0 = done_cnt; len = 16'h0002; req = 2'b01; b = 0;
    while (grant == 2'b00 && b < 200) begin tick(1); b++; end
    check("s4_grant", grant, 2'b01);
    tick(1); req = 2'b00; b = 0;
    while (done_cnt == d0 && b < 2000) begin tick(1); b++; end
    check("s4_done", done_cnt - d0, 1);

    // reset during WAIT_DONE of byte 2 of 4
    do_reset;
    len = 16'h0003; req = 2'b01; b = 0;
    while (!(active && issued == 2 && !core_done) && b < 2000) begin tick(1); b++; end
    check("s5_reached", issued, 2);
    rst = 1'b1; d0 = done_cnt;
    #1;
    check("s5_cs_rst", cs_n, 2'b11);
    check("s5_grant_rst", grant, 2'b00);
    req = 2'b00; tick(2); rst = 1'b0; tick(3);
    check("s5_no_done", done_cnt, d0);
    txb[1] = 8'hA5;
    run_txn(2'b10, 8'd0, 8'd0, 1);
    check("s5_rx1", last_rx[1], 8'h3C);

    // random traffic
    repeat (25) begin
      run_txn(2'($urandom_range(1, 3)), 8'($urandom_range(0, 4)),
              8'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0) ? 2 : 1);
      tick($urandom_range(0, 3));
    end

    // longest transaction: len all-ones -> 256 bytes
    run_txn(2'b01, 8'hFF, 8'h00, 1);
    check("len_max_bytes", issued, 256);

    // engine never finishes
    hang = 1;
`ifdef SPI_ARB_TIMEOUT_EN
    run_txn(2'b01, 8'd1, 8'd0, 1);
    check("s6_err", err, 1);
    tick(5);
    check("s6_err_sticky", err, 1);
    check("s6_cs_released", cs_n, 2'b11);
`else
    d0 = done_cnt; len = 16'h0000; req = 2'b01;
    tick(150);
    req = 2'b00;
    check("s6_stuck_grant", grant, 2'b01);
    check("s6_stuck_cs", cs_n, 2'b10);
    check("s6_no_err", err, 0);
    check("s6_no_done", done_cnt, d0);
`endif
    do_reset;
    check("final_err_cleared", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
